// File: rtl/piso_pkg.sv
// Shared types and sizing helpers for the parallel-in/serial-out serializer.
// Frame length accounts for the optional parity bit (PISO_SERIALIZER_PARITY_EN).
package piso_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  function automatic int frame_len(input int width, input bit parity_en);
    return parity_en ? width + 1 : width;
  endfunction

  function automatic int cnt_width(input int flen);
    int w;
    w = $clog2(flen);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/piso_bit_counter.sv
// Loadable down-counter tracking the bits left in the current serial frame.
// zero flags the final bit; load takes priority over dec.
module piso_bit_counter #(
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out launcher with valid/ready on both sides and back-to-back frames.
// Define PISO_SERIALIZER_PARITY_EN to append an even-parity bit after each data word.
module piso_serializer
  import piso_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             ser_ready,
  output logic             ser_valid,
  output logic             ser_data,
  output logic             ser_last,
  output logic             busy
);

`ifdef PISO_SERIALIZER_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif
  localparam int FLEN  = frame_len(WIDTH, PAR_EN);
  localparam int CNT_W = cnt_width(FLEN);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sr_p0;
  logic             cnt_zero;
  logic             load;
  logic             beat;
  logic             dec;
  logic             data_bit;
  logic             ser_bit;

  assign data_bit = LSB_FIRST ? sr_p0[0] : sr_p0[WIDTH-1];

`ifdef PISO_SERIALIZER_PARITY_EN
  logic par_p0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      par_p0 <= 1'b0;
    end else if (load) begin
      par_p0 <= ^in_data;
    end
  end

  // Count reaches zero only on the trailing parity slot.
  assign ser_bit = cnt_zero ? par_p0 : data_bit;
`else
  assign ser_bit = data_bit;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    ser_valid = 1'b0;
    ser_data  = 1'b0;
    ser_last  = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = SHIFT;
      end
      SHIFT: begin
        ser_valid = 1'b1;
        busy      = 1'b1;
        ser_data  = ser_bit;
        ser_last  = cnt_zero;
        // Opening the input on the final beat lets the next word follow with no bubble.
        in_ready  = cnt_zero & ser_ready;
        if (cnt_zero && ser_ready && !in_valid) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign load = in_valid & in_ready;
  assign beat = ser_valid & ser_ready;
  assign dec  = beat & ~cnt_zero;

  // Shift stage: load wins over shift so the last beat can hand over to a new word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_p0 <= '0;
    end else if (load) begin
      sr_p0 <= in_data;
    end else if (beat) begin
      sr_p0 <= LSB_FIRST ? {1'b0, sr_p0[WIDTH-1:1]} : {sr_p0[WIDTH-2:0], 1'b0};
    end
  end

  piso_bit_counter #(
    .CNT_W(CNT_W)
  ) u_cnt (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .load_val(CNT_W'(FLEN - 1)),
    .dec     (dec),
    .zero    (cnt_zero)
  );

endmodule

// File: tb/tb_piso_serializer.sv
// Self-checking bench for piso_serializer: LSB-first and MSB-first instances share stimulus.
// Honours PISO_SERIALIZER_PARITY_EN to expect the trailing parity bit.
module tb_piso_serializer;

`ifdef PISO_SERIALIZER_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif
  localparam int FLEN = PAR ? 9 : 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_data;
  logic       ser_ready;

  logic l_in_ready, l_ser_valid, l_ser_data, l_ser_last, l_busy;
  logic m_in_ready, m_ser_valid, m_ser_data, m_ser_last, m_busy;

  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(8), .LSB_FIRST(1'b1)) u_lsb (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(l_in_ready), .in_data(in_data),
    .ser_ready(ser_ready), .ser_valid(l_ser_valid), .ser_data(l_ser_data),
    .ser_last(l_ser_last), .busy(l_busy)
  );

  piso_serializer #(.WIDTH(8), .LSB_FIRST(1'b0)) u_msb (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(m_in_ready), .in_data(in_data),
    .ser_ready(ser_ready), .ser_valid(m_ser_valid), .ser_data(m_ser_data),
    .ser_last(m_ser_last), .busy(m_busy)
  );

  typedef struct packed {
    logic d;
    logic last;
  } sbit_t;

  // msb_stream bit i is the i-th bit sent by the MSB-first instance.
  typedef struct {
    logic [7:0] data;
    logic [7:0] msb_stream;
    logic       par;
    logic       rnd;
  } vec_t;

  vec_t  tbl[9];
  sbit_t ql[$];
  sbit_t qm[$];
  int    checks   = 0;
  int    failures = 0;
  int    cur_idx  = 0;
  logic  acc_flag;
  logic  rnd_ready = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_frame(input int idx);
    for (int i = 0; i < 8; i++) begin
      ql.push_back('{d: tbl[idx].data[i],       last: (i == 7) && !PAR});
      qm.push_back('{d: tbl[idx].msb_stream[i], last: (i == 7) && !PAR});
    end
    if (PAR) begin
      ql.push_back('{d: tbl[idx].par, last: 1'b1});
      qm.push_back('{d: tbl[idx].par, last: 1'b1});
    end
  endtask

  // One clock: check outputs against the scoreboard, advance it, step to the next negedge.
  task automatic cycle();
    logic evld, erdy, beat;
    if (rnd_ready) ser_ready = 1'($urandom_range(0, 1));
    #1;
    evld = (ql.size() != 0);
    erdy = !evld || (ql.size() == 1 && ser_ready);
    chk("lsb_valid", l_ser_valid, evld);
    chk("msb_valid", m_ser_valid, evld);
    chk("lsb_busy", l_busy, evld);
    chk("msb_busy", m_busy, evld);
    chk("lsb_in_ready", l_in_ready, erdy);
    chk("msb_in_ready", m_in_ready, erdy);
    if (evld) begin
      chk("lsb_data", l_ser_data, ql[0].d);
      chk("msb_data", m_ser_data, qm[0].d);
      chk("lsb_last", l_ser_last, ql[0].last);
      chk("msb_last", m_ser_last, qm[0].last);
    end else begin
      chk("lsb_last_idle", l_ser_last, 1'b0);
      chk("msb_last_idle", m_ser_last, 1'b0);
    end
    acc_flag = in_valid && erdy;
    beat     = evld && ser_ready;
    if (beat) begin
      void'(ql.pop_front());
      void'(qm.pop_front());
    end
    if (acc_flag) push_frame(cur_idx);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic offer(input int idx);
    in_valid = 1'b1;
    in_data  = tbl[idx].data;
    cur_idx  = idx;
  endtask

  task automatic wait_accept(output int ncyc);
    ncyc = 0;
    acc_flag = 1'b0;
    while (!acc_flag && ncyc < 60) begin
      cycle();
      ncyc++;
    end
    chk("accept_timeout", acc_flag, 1'b1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    in_valid = 1'b0;
    in_data  = 8'($urandom);
    while (ql.size() != 0 && n < 200) begin
      cycle();
      n++;
    end
    chk("drain_timeout", ql.size(), 0);
  endtask

  initial begin
    int n;
    int gap;
    tbl[0] = '{8'hA5, 8'hA5, 1'b0, 1'b0};
    tbl[1] = '{8'h80, 8'h01, 1'b1, 1'b0};
    tbl[2] = '{8'h0F, 8'hF0, 1'b0, 1'b0};
    tbl[3] = '{8'hF0, 8'h0F, 1'b0, 1'b0};
    tbl[4] = '{8'h3C, 8'h3C, 1'b0, 1'b0};
    tbl[5] = '{8'h5A, 8'h5A, 1'b0, 1'b1};
    tbl[6] = '{8'h01, 8'h80, 1'b1, 1'b0};
    tbl[7] = '{8'h07, 8'hE0, 1'b1, 1'b1};
    tbl[8] = '{8'h03, 8'hC0, 1'b0, 1'b0};

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    ser_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_lsb_valid", l_ser_valid, 1'b0);
    chk("rst_lsb_data", l_ser_data, 1'b0);
    chk("rst_lsb_last", l_ser_last, 1'b0);
    chk("rst_lsb_busy", l_busy, 1'b0);
    chk("rst_lsb_in_ready", l_in_ready, 1'b1);
    chk("rst_msb_in_ready", m_in_ready, 1'b1);
    rst = 1'b0;

    // ser_ready in IDLE must not start anything.
    ser_ready = 1'b1;
    for (int i = 0; i < 3; i++) cycle();

    // Table pass: single frames, some with random backpressure.
    for (int i = 0; i < 9; i++) begin
      rnd_ready = tbl[i].rnd;
      offer(i);
      wait_accept(n);
      drain();
      rnd_ready = 1'b0;
      ser_ready = 1'b1;
      cycle();
    end

    // Back-to-back 0x0F then 0xF0 with in_valid held.
    ser_ready = 1'b1;
    offer(2);
    wait_accept(n);
    offer(3);
    wait_accept(gap);
    chk("b2b_gap", gap, FLEN);
    drain();
    cycle();

    // Backpressure cycles 3-5 during a 0x3C frame.
    offer(4);
    wait_accept(n);
    in_valid = 1'b0;
    n = 0;
    while (ql.size() != 0 && n < 40) begin
      n++;
      ser_ready = !(n >= 3 && n <= 5);
      cycle();
    end
    chk("bp_done_cycle", n, FLEN + 3);
    ser_ready = 1'b1;
    cycle();

    // Asynchronous reset in cycle 4 of a frame.
    offer(5);
    wait_accept(n);
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) cycle();
    #2 rst = 1'b1;
    #1;
    chk("arst_lsb_valid", l_ser_valid, 1'b0);
    chk("arst_msb_valid", m_ser_valid, 1'b0);
    chk("arst_lsb_busy", l_busy, 1'b0);
    chk("arst_lsb_last", l_ser_last, 1'b0);
    chk("arst_lsb_data", l_ser_data, 1'b0);
    chk("arst_in_ready", l_in_ready, 1'b1);
    ql.delete();
    qm.delete();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    cycle();
    cycle();
    offer(6);
    wait_accept(n);
    drain();
    cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=%0t required=finish", $time);
    $fatal(1, "timeout");
  end

endmodule
